// File: rtl/io_bus_responder_pkg.sv
// Shared address map, status bit positions and helpers for the IO bus responder.
// Decode is exact on the 8-bit IO byte address.
package io_bus_responder_pkg;

  localparam logic [7:0] IO_LED        = 8'h00;
  localparam logic [7:0] IO_OUT_STATUS = 8'h04;
  localparam logic [7:0] IO_SEG        = 8'h08;
  localparam logic [7:0] IO_IN_STATUS  = 8'h0C;
  localparam logic [7:0] IO_SW         = 8'h10;
  localparam logic [7:0] IO_CYCLE      = 8'h14;

  localparam int OUT_READY_BIT = 0;
  localparam int IN_VALID_BIT  = 0;
  localparam int OVERRUN_BIT   = 1;

  typedef enum logic {
    OUT_IDLE,
    OUT_BUSY
  } out_state_e;

  function automatic logic [3:0] digit_sel(input logic [31:0] data, input logic [2:0] idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/io_bus_responder_debouncer.sv
// Level debouncer: output follows din once din has differed from it for DEBOUNCE_CYCLES
// consecutive cycles; rise pulses on the edge where the output goes 0 -> 1.
module io_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          settle;

  assign settle = (din != dout) && (cnt == CNT_LAST);
  assign rise   = settle && din;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din != dout) begin
      if (settle) begin
        dout <= din;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      // any return to the current level restarts the qualification window
      cnt <= '0;
    end
  end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped IO responder: LED register, scanned seven-segment output, debounced
// switch capture and a free-running cycle counter. Writes land on the io_we edge; reads are combinational.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SCAN_CYCLES     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic [7:0]  sw,
  input  logic        btn,
  output logic [7:0]  led,
  output logic [2:0]  an,
  output logic [3:0]  seg
);

  localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_CYCLES - 1);

  logic wr_led, wr_seg, wr_ack;

  assign wr_led = io_we && (io_addr == IO_LED);
  assign wr_seg = io_we && (io_addr == IO_SEG);
  assign wr_ack = io_we && (io_addr == IO_IN_STATUS);

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else if (wr_led) begin
      led <= io_dout[7:0];
    end
  end

  // Seven-segment data and scan
  logic [31:0]   seg_reg;
  logic [DW-1:0] div;
  logic          wrap;

  assign wrap = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= '0;
    end else if (wr_seg) begin
      seg_reg <= io_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wr_seg) begin
      div <= '0;
      an  <= '0;
    end else if (wrap) begin
      div <= '0;
      an  <= an + 3'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign seg = digit_sel(seg_reg, an);

  // Output-ready tracking: busy from a SEG write until the scan wraps past digit 7
  out_state_e out_state, out_state_next;
  logic       out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= OUT_IDLE;
    end else begin
      out_state <= out_state_next;
    end
  end

  always_comb begin
    out_state_next = out_state;
    case (out_state)
      OUT_IDLE: begin
        if (wr_seg) out_state_next = OUT_BUSY;
      end
      OUT_BUSY: begin
        if (!wr_seg && wrap && (an == 3'd7)) out_state_next = OUT_IDLE;
      end
      default: out_state_next = OUT_IDLE;
    endcase
  end

  assign out_ready = (out_state == OUT_IDLE);

  // Input path: synchronize sw and btn, debounce btn
  logic [7:0] sw_s1, sw_s2;
  logic       btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  logic btn_level, deb_rise, btn_rise;

  io_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst  (rst),
    .din  (btn_s2),
    .dout (btn_level),
    .rise (deb_rise)
  );

  assign btn_rise = deb_rise && !btn_level;

  logic [7:0] sw_reg;
  logic       in_valid, overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_reg   <= '0;
      in_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (wr_ack) begin
        in_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      // a rise coinciding with an ack is treated as a fresh capture
      if (btn_rise) begin
        if (!in_valid || wr_ack) begin
          sw_reg   <= sw_s2;
          in_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  // Cycle counter
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Read mux
  always_comb begin
    io_din = '0;
    case (io_addr)
      IO_OUT_STATUS: io_din[OUT_READY_BIT] = out_ready;
      IO_IN_STATUS: begin
        io_din[IN_VALID_BIT] = in_valid;
        io_din[OVERRUN_BIT]  = overrun;
      end
      IO_SW:    io_din = {24'b0, sw_reg};
      IO_CYCLE: io_din = cycle_cnt;
      default:  io_din = '0;
    endcase
  end

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder with short debounce and scan periods.
module tb_io_bus_responder;

  localparam int DEB  = 4;
  localparam int SCAN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we;
  logic [31:0] io_din;
  logic [7:0]  sw;
  logic        btn;
  logic [7:0]  led;
  logic [2:0]  an;
  logic [3:0]  seg;

  int n_checks = 0;
  int n_errors = 0;

  io_bus_responder #(
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_we   (io_we),
    .io_din  (io_din),
    .sw      (sw),
    .btn     (btn),
    .led     (led),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic [31:0] exp_din;
    logic [7:0]  exp_led;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    io_addr = a;
    #1;
    check(name, io_din, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_we   = 1'b1;
    io_addr = a;
    io_dout = d;
    tick();
    io_we   = 1'b0;
  endtask

  task automatic press(input logic [7:0] v);
    sw  = v;
    btn = 1'b1;
    repeat (8) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int exp_an;
    int n;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        32'h0, 8'h00};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        32'h1, 8'h00};
    vecs[2]  = '{1'b0, 8'h0C, 32'h0,        32'h0, 8'h00};
    vecs[3]  = '{1'b0, 8'h10, 32'h0,        32'h0, 8'h00};
    vecs[4]  = '{1'b1, 8'h00, 32'h000001A5, 32'h0, 8'hA5};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,        32'h1, 8'hA5};
    vecs[6]  = '{1'b1, 8'h04, 32'h000000FF, 32'h1, 8'hA5};
    vecs[7]  = '{1'b0, 8'h04, 32'h0,        32'h1, 8'hA5};
    vecs[8]  = '{1'b1, 8'h10, 32'h00000077, 32'h0, 8'hA5};
    vecs[9]  = '{1'b0, 8'h10, 32'h0,        32'h0, 8'hA5};
    vecs[10] = '{1'b1, 8'h01, 32'h00000033, 32'h0, 8'hA5};
    vecs[11] = '{1'b1, 8'h80, 32'h00000012, 32'h0, 8'hA5};
    vecs[12] = '{1'b1, 8'h00, 32'h0000005A, 32'h0, 8'h5A};
    vecs[13] = '{1'b0, 8'h40, 32'h0,        32'h0, 8'h5A};

    rst = 1'b1; io_we = 1'b0; io_addr = '0; io_dout = '0; sw = '0; btn = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    check("rst_led", {24'b0, led}, 32'h0);
    check("rst_an", {29'b0, an}, 32'h0);
    check("rst_seg", {28'b0, seg}, 32'h0);
    rd(8'h04, 32'h1, "rst_out_status");
    rd(8'h0C, 32'h0, "rst_in_status");
    rd(8'h10, 32'h0, "rst_sw_data");
    rd(8'h14, 32'h0, "rst_cycle");

    // register access table
    for (int i = 0; i < NV; i++) begin
      io_we   = vecs[i].we;
      io_addr = vecs[i].addr;
      io_dout = vecs[i].dout;
      #1;
      check($sformatf("vec%0d_din", i), io_din, vecs[i].exp_din);
      tick();
      io_we = 1'b0;
      check($sformatf("vec%0d_led", i), {24'b0, led}, {24'b0, vecs[i].exp_led});
    end

    // single SEG write: full pass of 8*SCAN cycles
    wr(8'h08, 32'h76543210);
    check("seg_w_an", {29'b0, an}, 32'h0);
    check("seg_w_seg", {28'b0, seg}, 32'h0);
    rd(8'h04, 32'h0, "seg_w_busy");
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_an = (k / SCAN) % 8;
      check($sformatf("scan1_an_k%0d", k), {29'b0, an}, 32'(exp_an));
      check($sformatf("scan1_seg_k%0d", k), {28'b0, seg}, 32'(exp_an));
      rd(8'h04, (k >= 16) ? 32'h1 : 32'h0, $sformatf("scan1_ready_k%0d", k));
    end

    // second write at cycle 10 restarts the pass
    wr(8'h08, 32'h76543210);
    for (int k = 1; k <= 26; k++) begin
      if (k == 10) begin
        io_we = 1'b1; io_addr = 8'h08; io_dout = 32'hFEDCBA98;
      end
      tick();
      io_we = 1'b0;
      if (k < 10) begin
        exp_an = (k / SCAN) % 8;
        check($sformatf("scan2_seg_k%0d", k), {28'b0, seg}, 32'(exp_an));
      end else begin
        exp_an = ((k - 10) / SCAN) % 8;
        check($sformatf("scan2_seg_k%0d", k), {28'b0, seg}, 32'(8 + exp_an));
      end
      check($sformatf("scan2_an_k%0d", k), {29'b0, an}, 32'(exp_an));
      rd(8'h04, (k >= 26) ? 32'h1 : 32'h0, $sformatf("scan2_ready_k%0d", k));
    end

    // bouncy press: 1-0-1 then hold
    sw = 8'h3C;
    btn = 1'b1; tick();
    btn = 1'b0; tick();
    btn = 1'b1; tick();
    rd(8'h0C, 32'h0, "deb_t3");
    tick();
    rd(8'h0C, 32'h0, "deb_t4");
    for (int j = 1; j <= DEB; j++) begin
      tick();
      rd(8'h0C, (j == DEB) ? 32'h1 : 32'h0, $sformatf("deb_stable_plus%0d", j));
    end
    rd(8'h10, 32'h3C, "deb_sw_data");
    rd(8'h0C, 32'h1, "deb_in_status");
    btn = 1'b0;
    repeat (8) tick();

    // overrun
    wr(8'h0C, 32'h0);
    rd(8'h0C, 32'h0, "ovr_acked");
    press(8'h11);
    press(8'h22);
    rd(8'h10, 32'h11, "ovr_sw_data");
    rd(8'h0C, 32'h3, "ovr_in_status");
    wr(8'h0C, 32'hDEAD);
    rd(8'h0C, 32'h0, "ovr_cleared");
    rd(8'h10, 32'h11, "ovr_sw_kept");

    // ack coinciding with a debounced rise, while in_valid is already set
    press(8'h33);
    rd(8'h0C, 32'h1, "sim_pre_valid");
    sw = 8'h5A;
    btn = 1'b1;
    repeat (5) tick();
    rd(8'h10, 32'h33, "sim_pre_sw");
    io_we = 1'b1; io_addr = 8'h0C; io_dout = 32'h0;
    tick();
    io_we = 1'b0;
    rd(8'h0C, 32'h1, "sim_in_status");
    rd(8'h10, 32'h5A, "sim_sw_data");
    btn = 1'b0;
    repeat (8) tick();

    // reset mid-scan with an LED write attempted during reset
    wr(8'h08, 32'h76543210);
    repeat (5 * SCAN) tick();
    check("mid_an5", {29'b0, an}, 32'h5);
    rd(8'h04, 32'h0, "mid_busy");
    rd(8'h0C, 32'h1, "mid_valid");
    rst = 1'b1; btn = 1'b1;
    io_we = 1'b1; io_addr = 8'h00; io_dout = 32'hFF;
    tick();
    io_we = 1'b0;
    check("mrst_led", {24'b0, led}, 32'h0);
    check("mrst_an", {29'b0, an}, 32'h0);
    check("mrst_seg", {28'b0, seg}, 32'h0);
    rd(8'h04, 32'h1, "mrst_out_status");
    rd(8'h0C, 32'h0, "mrst_in_status");
    rd(8'h10, 32'h0, "mrst_sw_data");
    rd(8'h14, 32'h0, "mrst_cycle");
    rst = 1'b0;
    tick();
    rd(8'h14, 32'h1, "post_rst_cycle");
    rd(8'h40, 32'h0, "post_rst_unmapped");

    // btn held through reset produces a rise, not before DEBOUNCE_CYCLES
    n = 1;
    io_addr = 8'h0C;
    #1;
    while (io_din[0] == 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("held_rise_seen", {31'b0, io_din[0]}, 32'h1);
    check("held_rise_not_early", (n >= DEB) ? 32'h1 : 32'h0, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
